// File: rtl/return_stack_if.sv
// Connection bundle between the control unit's jal/jr decode and the return-address stack.
// The control side drives push/pop/flush/pc; the stack drives the prediction and status.
interface return_stack_if #(
  parameter int AW = 3
);
  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] ret_addr;
  logic        ret_valid;
  logic        empty;
  logic        full;
  logic        overflow;
  logic [AW:0] count;

  modport master (
    output push, pop, flush, pc,
    input  ret_addr, ret_valid, empty, full, overflow, count
  );

  modport slave (
    input  push, pop, flush, pc,
    output ret_addr, ret_valid, empty, full, overflow, count
  );
endinterface

// File: rtl/return_stack.sv
// Return-address stack for the single-cycle MIPS core: jal pushes pc+4, jr $ra pops the
// predicted target one cycle later. Circular storage; a push when full drops the oldest entry.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  return_stack_if.slave bus
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] TP_ONE  = AW'(1);

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] tp_r;
  logic [AW:0]   count_r;
  logic [31:0]   ret_addr_r;
  logic          ret_valid_r;
  logic          overflow_r;
  logic          empty_r;
  logic          full_r;

  logic [AW-1:0] tp_n_s;
  logic [AW:0]   count_n_s;
  logic [31:0]   ret_addr_n_s;
  logic          ret_valid_n_s;
  logic          overflow_n_s;
  logic          empty_n_s;
  logic          full_n_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] top_s;
  logic          has_entry_s;
  logic [31:0]   link_s;

  assign top_s       = tp_r - TP_ONE;
  assign has_entry_s = (count_r != {(AW+1){1'b0}});
  assign link_s      = bus.pc + 32'd4;

  // Next-state decode of the stack pointer, occupancy, prediction and array write.
  always_comb begin
    tp_n_s        = tp_r;
    count_n_s     = count_r;
    overflow_n_s  = overflow_r;
    ret_addr_n_s  = ret_addr_r;
    ret_valid_n_s = 1'b0;
    wr_en_s       = 1'b0;
    wr_idx_s      = tp_r;
    if (bus.flush) begin
      tp_n_s       = {AW{1'b0}};
      count_n_s    = {(AW+1){1'b0}};
      overflow_n_s = 1'b0;
      ret_addr_n_s = 32'h0;
    end else begin
      case ({bus.push, bus.pop, has_entry_s})
        // Push alone, or push+pop on an empty stack (nothing to return).
        3'b100, 3'b101, 3'b110: begin
          wr_en_s = 1'b1;
          tp_n_s  = tp_r + TP_ONE;
          if (count_r == DEPTH_C) begin
            overflow_n_s = 1'b1;
          end else begin
            count_n_s = count_r + (AW+1)'(1);
          end
        end
        3'b011: begin
          ret_addr_n_s  = mem_r[top_s];
          ret_valid_n_s = 1'b1;
          tp_n_s        = top_s;
          count_n_s     = count_r - (AW+1)'(1);
        end
        // Return the current top and reuse its slot for the new link address.
        3'b111: begin
          ret_addr_n_s  = mem_r[top_s];
          ret_valid_n_s = 1'b1;
          wr_en_s       = 1'b1;
          wr_idx_s      = top_s;
        end
        3'b010: begin
          ret_addr_n_s = 32'h0;
        end
        default: begin
          ret_addr_n_s = ret_addr_r;
        end
      endcase
    end
    empty_n_s = (count_n_s == {(AW+1){1'b0}});
    full_n_s  = (count_n_s == DEPTH_C);
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tp_r        <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      ret_addr_r  <= 32'h0;
      ret_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
    end else begin
      tp_r        <= tp_n_s;
      count_r     <= count_n_s;
      ret_addr_r  <= ret_addr_n_s;
      ret_valid_r <= ret_valid_n_s;
      overflow_r  <= overflow_n_s;
      empty_r     <= empty_n_s;
      full_r      <= full_n_s;
    end
  end

  // Entry storage; contents are meaningless until written, so it carries no reset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= link_s;
    end
  end

  assign bus.ret_addr  = ret_addr_r;
  assign bus.ret_valid = ret_valid_r;
  assign bus.count     = count_r;
  assign bus.overflow  = overflow_r;
  assign bus.empty     = empty_r;
  assign bus.full      = full_r;

endmodule

// File: doc/return_stack.md
# return_stack

Hardware return-address stack for the single-cycle MIPS core: the return side of the jump path. On every `jal` it records the link address, PC+4. On every `jr $ra` it supplies the predicted return target, one cycle later, to the PC-select logic. It sits beside the jump-target generator. It is driven by the control unit's `jal`/`jr` decode and never stalls the core.

## Interface
- `DEPTH`, 8: number of entries; power of two, 2 to 64.
- `AW`, 3: pointer width; equals log2(DEPTH).
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `push` input 1: current instruction is `jal`; store `pc + 4`.
- `pc` input 32: PC of the current instruction; sampled only when `push` = 1.
- `pop` input 1: current instruction is `jr` with rs = $ra (register 31); consume the top entry.
- `flush` input 1: synchronous clear of the whole stack; takes priority over `push` and `pop`.
- `ret_addr` output 32: return address popped in the previous cycle; registered.
- `ret_valid` output 1: `ret_addr` holds a real entry (1-cycle pulse).
- `empty` output 1: count = 0.
- `full` output 1: count = DEPTH.
- `count` output AW+1: number of valid entries, 0 to DEPTH.
- `overflow` output 1: sticky; set when a push overwrote the oldest entry. Cleared only by reset or `flush`.

## Operation
- **Storage:** circular array of DEPTH 32-bit entries, plus top pointer `tp` (AW bits) and `count`. `tp` points to the next free slot; the top of stack is `tp-1` mod DEPTH.
- **Push only:** `mem[tp] <= pc + 32'd4`, computed as 32-bit modulo addition. Then `tp <= tp+1` mod DEPTH.
  - If count < DEPTH: count increments.
  - If full: count stays at DEPTH, the oldest entry is silently overwritten, and `overflow <= 1`.
- **Pop only, count > 0:** `ret_addr <= mem[tp-1]`, `ret_valid <= 1`, `tp <= tp-1`, `count <= count-1`.
- **Pop only, empty (underflow):** `ret_addr <= 32'h0`, `ret_valid <= 0`. `tp` and `count` are unchanged. No error flag; the core falls back to the register-file value.
- **Push and pop in the same cycle:** the pop reads the current top into `ret_addr` with `ret_valid = 1`. The new link value then replaces that same slot: `mem[tp-1] <= pc+4`. `tp` and `count` are unchanged.
  - If empty: acts as push only, and `ret_valid = 0`.
- **Flush:** `tp <= 0`, `count <= 0`, `overflow <= 0`, `ret_valid <= 0`, `ret_addr <= 0`. Array contents are don't-care.
- **Idle cycles** (no push, pop or flush): `ret_valid <= 0`. `ret_addr` holds its value.
- **Combinational outputs:** `empty` and `full` are decoded from `count`.

## Timing
- **Reset (`reset_n` low, asynchronous):** `tp` = 0, `count` = 0, `ret_addr` = 32'h0, `ret_valid` = 0, `overflow` = 0. Therefore `empty` = 1 and `full` = 0.
  - Array contents are not reset.
  - Reset asserted mid-operation takes effect immediately. After release, the first edge behaves as in a fresh start.
- **Pop latency:** 1 cycle. `pop` sampled at edge N gives `ret_addr`/`ret_valid` valid after edge N, for the whole cycle N..N+1.
- **Push visibility:** a push at edge N is visible to a pop sampled at edge N+1, i.e. back-to-back `jal` then `jr` works.
- **Throughput:** one push and/or one pop per cycle; no handshake and no backpressure.
- **Status timing:** `count`, `full`, `empty` and `overflow` reflect state after the most recent edge.
- **Pointer wrap:** `tp` wraps from DEPTH-1 to 0 on push and from 0 to DEPTH-1 on pop. There is no special-case logic.

## Test plan
- **Reset then simple push/pop:** reset, push with pc=0x0040_0010, then pop the next cycle. Expect `ret_addr`=0x0040_0014 and `ret_valid`=1 for one cycle; `count` goes 0→1→0; `empty`=1 at the end.
- **Nesting (DEPTH=8):** push pc=0x100, 0x200, 0x300, then pop three times. Expect returns 0x304, 0x204, 0x104 in that order, each one cycle after its pop.
- **Overflow and wrap:** push 9 times with pc=0x1000+0x10·k, k=0..8. Expect `full`=1 from the 8th push, `overflow`=1 after the 9th, `count`=8. Then 8 pops return 0x1084 down to 0x1014 (0x1004 lost). A 9th pop gives `ret_valid`=0, `ret_addr`=0.
- **Simultaneous push+pop:** after pushing pc=0x500, assert push (pc=0x600) and pop together. Expect `ret_addr`=0x504 with `ret_valid`=1 and `count` still 1. A following pop returns 0x604.
- **Empty push+pop and pc+4 wrap:** from empty, push+pop with pc=0xFFFF_FFFC. Expect `ret_valid`=0 and `count`=1. The next pop returns 0x0000_0000 with `ret_valid`=1.
- **Flush and async reset:** with `count`=3 and `overflow`=1, assert `flush` together with `push`. Expect `count`=0, `overflow`=0, `empty`=1, with the push ignored. Separately, drop `reset_n` between clock edges and check that all outputs clear immediately.
